// File: rtl/sm3_expnd_pkg.sv
// Shared types, constants and word functions for the SM3 message expansion engine.
package sm3_expnd_pkg;

    // Number of (Wj, W'j) pairs produced per 512-bit block.
    localparam int SM3_EXPND_STEPS = 64;
    // Words in one padded block and in the sliding expansion window.
    localparam int SM3_WIN_WORDS   = 16;

    typedef logic [31:0] sm3_word_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_EXPND = 1'b1
    } sm3_expnd_st_e;

    // Rotate left by a constant amount in 1..31.
    function automatic sm3_word_t rotl32(input sm3_word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // SM3 permutation used during message expansion.
    function automatic sm3_word_t p1(input sm3_word_t x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expnd_wgen.sv
// Combinational generator for one expanded word Wn from its five window taps.
module sm3_expnd_wgen
    import sm3_expnd_pkg::*;
(
    input  logic [31:0] w16_i,   // Wn-16
    input  logic [31:0] w13_i,   // Wn-13
    input  logic [31:0] w9_i,    // Wn-9
    input  logic [31:0] w6_i,    // Wn-6
    input  logic [31:0] w3_i,    // Wn-3
    output logic [31:0] wn_o     // Wn
);

    sm3_word_t p1_in;

    // Wn = P1(Wn-16 ^ Wn-9 ^ rotl(Wn-3,15)) ^ rotl(Wn-13,7) ^ Wn-6
    always_comb begin
        p1_in = w16_i ^ w9_i ^ rotl32(w3_i, 15);
        wn_o  = p1(p1_in) ^ rotl32(w13_i, 7) ^ w6_i;
    end

endmodule

// File: rtl/sm3_expnd_core_p.sv
// SM3 message expansion: loads a 16-word block, then streams (Wj, W'j) pairs
// LANES at a time with valid/ready backpressure on the output side.
module sm3_expnd_core_p
    import sm3_expnd_pkg::*;
#(
    parameter int INPT_DW = 32,
    parameter int LANES   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INPT_DW-1:0]   pad_inpt_d_i,
    input  logic                 pad_inpt_vld_i,
    input  logic                 pad_inpt_lst_i,
    output logic                 pad_inpt_rdy_o,
    output logic [32*LANES-1:0]  expnd_otpt_wj_o,
    output logic [32*LANES-1:0]  expnd_otpt_wjj_o,
    output logic                 expnd_otpt_vld_o,
    output logic                 expnd_otpt_lst_o,
    input  logic                 expnd_otpt_rdy_i
);

    if (!(INPT_DW == 32 || INPT_DW == 64)) begin : g_bad_dw
        $error("sm3_expnd_core_p: INPT_DW must be 32 or 64");
    end
    if (!(LANES == 1 || LANES == 2)) begin : g_bad_lanes
        $error("sm3_expnd_core_p: LANES must be 1 or 2");
    end

    // Words per input beat.
    localparam int          IW      = INPT_DW / 32;
    localparam logic [3:0]  LD_STEP = 4'(IW);
    // ld_cnt value on the beat that completes the block (wraps to 0 after it).
    localparam logic [3:0]  LD_LAST = 4'(SM3_WIN_WORDS - IW);
    localparam logic [5:0]  J_STEP  = 6'(LANES);
    localparam logic [5:0]  J_LAST  = 6'(SM3_EXPND_STEPS - LANES);

    sm3_expnd_st_e st_q, st_d;
    logic [3:0]    ld_cnt_q, ld_cnt_d;
    logic [5:0]    j_q, j_d;
    logic          blk_lst_q, blk_lst_d;
    sm3_word_t     win_q [SM3_WIN_WORDS];
    sm3_word_t     win_d [SM3_WIN_WORDS];
    sm3_word_t     gen_w [LANES];
    logic          in_expnd;

    assign in_expnd = (st_q == ST_EXPND);

    // One generator per lane; window holds win[i] = W(j+i), so lane k
    // producing W(j+16+k) taps win[k], win[k+3], win[k+7], win[k+10], win[k+13].
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sm3_expnd_wgen u_wgen (
            .w16_i (win_q[k]),
            .w13_i (win_q[k+3]),
            .w9_i  (win_q[k+7]),
            .w6_i  (win_q[k+10]),
            .w3_i  (win_q[k+13]),
            .wn_o  (gen_w[k])
        );

        // Lane 0 (lowest j) sits in the MSBs; outputs read as zero outside EXPND.
        assign expnd_otpt_wj_o [32*(LANES-k)-1 -: 32] = in_expnd ? win_q[k] : '0;
        assign expnd_otpt_wjj_o[32*(LANES-k)-1 -: 32] = in_expnd ? (win_q[k] ^ win_q[k+4]) : '0;
    end

    assign expnd_otpt_lst_o = in_expnd && blk_lst_q && (j_q == J_LAST);

    // Next-state logic: block load in LOAD, window advance on each output transfer in EXPND.
    always_comb begin
        st_d             = st_q;
        ld_cnt_d         = ld_cnt_q;
        j_d              = j_q;
        blk_lst_d        = blk_lst_q;
        win_d            = win_q;
        pad_inpt_rdy_o   = 1'b0;
        expnd_otpt_vld_o = 1'b0;

        case (st_q)
            ST_LOAD: begin
                pad_inpt_rdy_o = 1'b1;
                if (pad_inpt_vld_i) begin
                    for (int i = 0; i < SM3_WIN_WORDS - IW; i++) begin
                        win_d[i] = win_q[i+IW];
                    end
                    // Earlier word of the beat is in the MSBs, so it lands at the lower index.
                    for (int k = 0; k < IW; k++) begin
                        win_d[SM3_WIN_WORDS-IW+k] = pad_inpt_d_i[INPT_DW-1-32*k -: 32];
                    end
                    ld_cnt_d = ld_cnt_q + LD_STEP;
                    if (ld_cnt_q == LD_LAST) begin
                        blk_lst_d = pad_inpt_lst_i;
                        j_d       = '0;
                        st_d      = ST_EXPND;
                    end
                end
            end
            ST_EXPND: begin
                expnd_otpt_vld_o = 1'b1;
                if (expnd_otpt_rdy_i) begin
                    for (int i = 0; i < SM3_WIN_WORDS - LANES; i++) begin
                        win_d[i] = win_q[i+LANES];
                    end
                    for (int k = 0; k < LANES; k++) begin
                        win_d[SM3_WIN_WORDS-LANES+k] = gen_w[k];
                    end
                    j_d = j_q + J_STEP;
                    if (j_q == J_LAST) begin
                        st_d     = ST_LOAD;
                        ld_cnt_d = '0;
                    end
                end
            end
            default: st_d = ST_LOAD;
        endcase
    end

    // Control state with synchronous reset; a partial block is simply abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_LOAD;
            ld_cnt_q  <= '0;
            j_q       <= '0;
            blk_lst_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            ld_cnt_q  <= ld_cnt_d;
            j_q       <= j_d;
            blk_lst_q <= blk_lst_d;
        end
    end

    // Window datapath carries no reset; its contents only matter after a full load.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

endmodule

// File: tb/tb_sm3_expnd_core_p.sv
// Bench for sm3_expnd_core_p: a 32-bit/1-lane and a 64-bit/2-lane instance,
// checked against an array-level SM3 expansion model.
module tb_sm3_expnd_core_p;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: INPT_DW=32, LANES=1
    logic [31:0] a_d;
    logic        a_vld, a_lst, a_irdy, a_ordy, a_ovld, a_olst;
    logic [31:0] a_wj, a_wjj;
    // Instance B: INPT_DW=64, LANES=2
    logic [63:0] b_d;
    logic        b_vld, b_lst, b_irdy, b_ordy, b_ovld, b_olst;
    logic [63:0] b_wj, b_wjj;

    sm3_expnd_core_p #(.INPT_DW(32), .LANES(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .pad_inpt_d_i(a_d), .pad_inpt_vld_i(a_vld), .pad_inpt_lst_i(a_lst),
        .pad_inpt_rdy_o(a_irdy),
        .expnd_otpt_wj_o(a_wj), .expnd_otpt_wjj_o(a_wjj),
        .expnd_otpt_vld_o(a_ovld), .expnd_otpt_lst_o(a_olst),
        .expnd_otpt_rdy_i(a_ordy)
    );

    sm3_expnd_core_p #(.INPT_DW(64), .LANES(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .pad_inpt_d_i(b_d), .pad_inpt_vld_i(b_vld), .pad_inpt_lst_i(b_lst),
        .pad_inpt_rdy_o(b_irdy),
        .expnd_otpt_wj_o(b_wj), .expnd_otpt_wjj_o(b_wjj),
        .expnd_otpt_vld_o(b_ovld), .expnd_otpt_lst_o(b_olst),
        .expnd_otpt_rdy_i(b_ordy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [68];
    logic [31:0] q_wj [$];
    logic [31:0] q_wjj[$];
    logic        q_lst[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] pm1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    task automatic compute_ref();
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int n = 16; n < 68; n++)
            ref_w[n] = pm1(ref_w[n-16] ^ ref_w[n-9] ^ rl(ref_w[n-3], 15))
                       ^ rl(ref_w[n-13], 7) ^ ref_w[n-6];
    endtask

    // ---------------- per-instance accessors ----------------
    function automatic logic irdy(input int s); return s ? b_irdy : a_irdy; endfunction
    function automatic logic ovld(input int s); return s ? b_ovld : a_ovld; endfunction
    function automatic logic ordy(input int s); return s ? b_ordy : a_ordy; endfunction
    function automatic logic [31:0] wj0(input int s); return s ? b_wj[63:32] : a_wj; endfunction
    function automatic int nbt(input int s); return s ? 8 : 16; endfunction

    task automatic drv_in(input int s, input logic v, input logic [31:0] hi,
                          input logic [31:0] lo, input logic l);
        if (s == 0) begin a_vld = v; a_d = hi; a_lst = l; end
        else begin b_vld = v; b_d = {hi, lo}; b_lst = l; end
    endtask

    task automatic set_ordy(input int s, input logic r);
        if (s == 0) a_ordy = r; else b_ordy = r;
    endtask

    // ---------------- output monitor and stall-hold checks ----------------
    logic        a_hold = 1'b0, b_hold = 1'b0;
    logic [31:0] a_hwj, a_hwjj;
    logic [63:0] b_hwj, b_hwjj;
    logic        a_hlst, b_hlst;

    always @(negedge clk) begin
        if (a_hold && a_ovld) begin
            chk("a_hold_wj", a_wj, a_hwj);
            chk("a_hold_wjj", a_wjj, a_hwjj);
            chk("a_hold_lst", a_olst, a_hlst);
        end
        if (b_hold && b_ovld) begin
            chk("b_hold_wj", b_wj, b_hwj);
            chk("b_hold_wjj", b_wjj, b_hwjj);
            chk("b_hold_lst", b_olst, b_hlst);
        end
        a_hold = !rst && a_ovld && !a_ordy;
        b_hold = !rst && b_ovld && !b_ordy;
        a_hwj = a_wj; a_hwjj = a_wjj; a_hlst = a_olst;
        b_hwj = b_wj; b_hwjj = b_wjj; b_hlst = b_olst;
        if (!rst && a_ovld && a_ordy) begin
            q_wj.push_back(a_wj); q_wjj.push_back(a_wjj); q_lst.push_back(a_olst);
        end
        if (!rst && b_ovld && b_ordy) begin
            q_wj.push_back(b_wj[63:32]); q_wjj.push_back(b_wjj[63:32]); q_lst.push_back(b_olst);
            q_wj.push_back(b_wj[31:0]);  q_wjj.push_back(b_wjj[31:0]);  q_lst.push_back(b_olst);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic do_reset();
        a_vld = 0; b_vld = 0; a_lst = 0; b_lst = 0; a_ordy = 0; b_ordy = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_irdy", a_irdy, 1); chk("rst_a_vld", a_ovld, 0); chk("rst_a_lst", a_olst, 0);
        chk("rst_a_wj", a_wj, 0);     chk("rst_a_wjj", a_wjj, 0);
        chk("rst_b_irdy", b_irdy, 1); chk("rst_b_vld", b_ovld, 0); chk("rst_b_lst", b_olst, 0);
        chk("rst_b_wj", b_wj, 0);     chk("rst_b_wjj", b_wjj, 0);
        @(posedge clk); #1;
    endtask

    // Drive nbeats beats of blk; lst is raised only on beat index lst_beat.
    task automatic load_beats(input int s, input int nbeats, input int lst_beat);
        int wpb;
        wpb = s ? 2 : 1;
        q_wj.delete(); q_wjj.delete(); q_lst.delete();
        for (int b = 0; b < nbeats; b++) begin
            drv_in(s, 1'b1, blk[b*wpb], s ? blk[b*wpb+1] : 32'h0, b == lst_beat);
            @(negedge clk);
            chk("in_rdy", irdy(s), 1);
            @(posedge clk); #1;
            if (b == nbt(s) - 1) begin
                drv_in(s, 1'b0, 32'h0, 32'h0, 1'b0);
                @(negedge clk);
                chk("lat_vld", ovld(s), 1);
                chk("rdy_fall", irdy(s), 0);
                chk("w0_first", wj0(s), blk[0]);
                @(posedge clk); #1;
            end
        end
        drv_in(s, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Accept npairs pairs with ready asserted pct% of cycles.
    task automatic drain(input int s, input int npairs, input int pct);
        int lanes, cnt, cyc;
        lanes = s ? 2 : 1; cnt = 0; cyc = 0;
        while (cnt * lanes < npairs && cyc < 3000) begin
            set_ordy(s, $urandom_range(99) < pct);
            @(negedge clk);
            if (ovld(s) && ordy(s)) cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        set_ordy(s, 1'b0);
        chk("xfer_cnt", cnt * lanes, npairs);
        if (npairs == 64) begin
            @(negedge clk);
            chk("rdy_back", irdy(s), 1);
            chk("vld_drop", ovld(s), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic verify(input int s, input int npairs, input logic blst);
        int lanes;
        lanes = s ? 2 : 1;
        compute_ref();
        chk("q_len", q_wj.size(), npairs);
        for (int j = 0; j < npairs && j < q_wj.size(); j++) begin
            chk($sformatf("wj[%0d]", j), q_wj[j], ref_w[j]);
            chk($sformatf("wjj[%0d]", j), q_wjj[j], ref_w[j] ^ ref_w[j+4]);
            chk($sformatf("lst[%0d]", j), q_lst[j], blst && (j >= 64 - lanes));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_d = '0; b_d = '0; a_vld = 0; b_vld = 0; a_lst = 0; b_lst = 0; a_ordy = 0; b_ordy = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int s = 0; s < 2; s++) begin
            // "abc" block, ready always high
            set_abc();
            load_beats(s, nbt(s), nbt(s) - 1);
            drain(s, 64, 100);
            chk("abc_wjj0", q_wjj.size() > 0 ? q_wjj[0] : 32'hx, 32'h61626380);
            chk("abc_wjj1", q_wjj.size() > 1 ? q_wjj[1] : 32'hx, 32'h00000000);
            chk("abc_w16", q_wj.size() > 16 ? q_wj[16] : 32'hx, 32'h9092e200);
            chk("abc_wjj12", q_wjj.size() > 12 ? q_wjj[12] : 32'hx, 32'h9092e200);
            verify(s, 64, 1'b1);

            // random block, 50% downstream ready
            rand_blk();
            load_beats(s, nbt(s), nbt(s) - 1);
            drain(s, 64, 50);
            verify(s, 64, 1'b1);

            // two blocks back to back, lst only on the second
            rand_blk();
            load_beats(s, nbt(s), -1);
            drain(s, 64, 50);
            verify(s, 64, 1'b0);
            rand_blk();
            load_beats(s, nbt(s), nbt(s) - 1);
            drain(s, 64, 50);
            verify(s, 64, 1'b1);

            // reset partway through a load, then a full block
            rand_blk();
            load_beats(s, s ? 3 : 7, -1);
            do_reset();
            rand_blk();
            load_beats(s, nbt(s), nbt(s) - 1);
            drain(s, 64, 100);
            verify(s, 64, 1'b1);

            // reset at j=30 of a last block, then a non-last block must show no lst
            rand_blk();
            load_beats(s, nbt(s), nbt(s) - 1);
            drain(s, 30, 50);
            verify(s, 30, 1'b1);
            do_reset();
            rand_blk();
            load_beats(s, nbt(s), -1);
            drain(s, 64, 100);
            verify(s, 64, 1'b0);

            // lst on a non-completing beat is ignored
            rand_blk();
            load_beats(s, nbt(s), s ? 2 : 4);
            drain(s, 64, 100);
            verify(s, 64, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
